// File: rtl/fibo_req_arbiter.sv
// fibo_req_arbiter: round-robin sharing of one Fibonacci calculator among NUM_REQ requesters.
// Define FIBO_ARB_TIMEOUT_EN to add a WAIT watchdog (TIMEOUT_CYC) and the sticky timeout_seen output.
module fibo_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 5,
  parameter int DATA_W  = 16,
  parameter int MAX_IDX = 24
`ifdef FIBO_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       err,
  output logic [DATA_W-1:0]        result,
  output logic                     busy,
  output logic [IDX_W-1:0]         calc_input_s,
  output logic                     calc_begin,
  input  logic                     calc_done,
  input  logic [DATA_W-1:0]        calc_fibo_out
`ifdef FIBO_ARB_TIMEOUT_EN
  ,
  output logic                     timeout_seen
`endif
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0] MAX_V = (IDX_W+1)'(MAX_IDX);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] g_q, g_d, rr_q, rr_d, pick, c;
  logic hold_q, hold_d, found, illegal;
  logic [IDX_W-1:0] pick_idx, in_q, in_d;
  logic [NUM_REQ-1:0] ack_q, ack_d, err_q, err_d, g_hot, pick_hot;
  logic [DATA_W-1:0] res_q, res_d;
  logic busy_q, busy_d, begin_q, begin_d;
`ifdef FIBO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic to_q, to_d;
  assign timeout_seen = to_q;
`endif
  assign ack = ack_q;
  assign err = err_q;
  assign result = res_q;
  assign busy = busy_q;
  assign calc_input_s = in_q;
  assign calc_begin = begin_q;
  // Scan downward so the nearest requester after rr (with wrap) wins.
  always_comb begin
    found = 1'b0;
    pick = rr_q;
    c = rr_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = GW'((int'(rr_q) + k) % NUM_REQ);
      if (req[c]) begin
        found = 1'b1;
        pick = c;
      end
    end
  end
  assign pick_idx = req_idx[int'(pick)*IDX_W +: IDX_W];
  assign illegal = {1'b0, pick_idx} > MAX_V;
  assign g_hot = NUM_REQ'(1) << g_q;
  assign pick_hot = NUM_REQ'(1) << pick;
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    rr_d = rr_q;
    hold_d = 1'b0;
    in_d = in_q;
    ack_d = '0;
    err_d = '0;
    res_d = res_q;
    begin_d = 1'b0;
`ifdef FIBO_ARB_TIMEOUT_EN
    cnt_d = '0;
    to_d = to_q;
`endif
    case (state_q)
      IDLE: if (found && !hold_q) begin
        g_d = pick;
        if (illegal) begin
          state_d = RESP;
          ack_d = pick_hot;
          err_d = pick_hot;
          res_d = '0;
        end else begin
          state_d = LAUNCH;
          in_d = pick_idx;
          begin_d = 1'b1;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: if (calc_done) begin
        state_d = RESP;
        ack_d = g_hot;
        res_d = calc_fibo_out;
      end
`ifdef FIBO_ARB_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        state_d = RESP;
        ack_d = g_hot;
        err_d = g_hot;
        res_d = '0;
        to_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
`endif
      default: begin
        state_d = IDLE;
        rr_d = g_q;
        hold_d = 1'b1;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      g_q <= '0;
      rr_q <= GW'(NUM_REQ - 1);
      hold_q <= 1'b0;
      in_q <= '0;
      ack_q <= '0;
      err_q <= '0;
      res_q <= '0;
      busy_q <= 1'b0;
      begin_q <= 1'b0;
`ifdef FIBO_ARB_TIMEOUT_EN
      cnt_q <= '0;
      to_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      rr_q <= rr_d;
      hold_q <= hold_d;
      in_q <= in_d;
      ack_q <= ack_d;
      err_q <= err_d;
      res_q <= res_d;
      busy_q <= busy_d;
      begin_q <= begin_d;
`ifdef FIBO_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
      to_q <= to_d;
`endif
    end
  end
endmodule

// File: tb/tb_fibo_req_arbiter.sv
// tb_fibo_req_arbiter: randomized + directed bench with a timestamp-based job model of the arbiter.
module tb_fibo_req_arbiter;
  localparam int N = 4, IW = 5, DW = 16, MAXI = 24;
`ifdef FIBO_ARB_TIMEOUT_EN
  localparam int TO = 64;
  logic timeout_seen;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req, ack, err;
  logic [N*IW-1:0] req_idx;
  logic [DW-1:0] result, calc_fibo_out;
  logic busy, calc_begin, calc_done;
  logic [IW-1:0] calc_input_s;
  fibo_req_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_idx(req_idx), .ack(ack), .err(err),
    .result(result), .busy(busy), .calc_input_s(calc_input_s), .calc_begin(calc_begin),
    .calc_done(calc_done), .calc_fibo_out(calc_fibo_out)
`ifdef FIBO_ARB_TIMEOUT_EN
    , .timeout_seen(timeout_seen)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, k = 0;
  bit rand_en = 0;
  int lat_fix = -1, done_at = -1, begins = 0;
  logic [IW-1:0] calc_latched, last_in;
  logic [N-1:0] rq;
  logic [IW-1:0] ridx [N];
  int drop_at [N];
  int ack_log [$];
  logic [DW-1:0] res_log [$];
  bit err_log [$];
  // Model: one job record with grant/ack timestamps.
  bit j_act, j_legal, j_err;
  int j_g, j_idx, j_t, j_ack, m_rr, next_free;
  logic [N-1:0] e_ack, e_err;
  logic [DW-1:0] e_res;
  logic [IW-1:0] e_in;
  bit e_busy, e_begin, e_to;
  function automatic logic [DW-1:0] fib(int n);
    logic [DW-1:0] a, b, t;
    a = '0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, k, got, exp);
    end
  endtask
  task automatic model_reset();
    j_act = 0; j_ack = -1; j_g = 0; m_rr = N - 1; next_free = 0;
    e_ack = '0; e_err = '0; e_res = '0; e_in = '0; e_busy = 0; e_begin = 0; e_to = 0;
  endtask
  task automatic model_step();
    e_ack = '0; e_err = '0; e_begin = 0;
    if (!j_act && k >= next_free && |req) begin
      j_g = -1;
      for (int s = 1; s <= N; s++) if (j_g < 0 && req[(m_rr + s) % N]) j_g = (m_rr + s) % N;
      j_act = 1; j_idx = int'(req_idx[j_g*IW +: IW]); j_legal = j_idx <= MAXI;
      j_err = !j_legal; j_t = k; j_ack = -1;
      if (!j_legal) begin j_ack = k; e_res = '0; end
      else begin e_begin = 1; e_in = IW'(j_idx); end
    end else if (j_act && j_legal && j_ack < 0 && k >= j_t + 2) begin
      if (calc_done) begin j_ack = k; e_res = calc_fibo_out; end
`ifdef FIBO_ARB_TIMEOUT_EN
      else if (k == j_t + 1 + TO) begin j_ack = k; j_err = 1; e_res = '0; e_to = 1; end
`endif
    end
    e_busy = j_act;
    if (j_act && j_ack == k) begin e_ack[j_g] = 1; e_err[j_g] = j_err; end
    if (j_act && j_ack >= 0 && k == j_ack + 1) begin
      j_act = 0; e_busy = 0; m_rr = j_g; next_free = k + 2;
    end
  endtask
  task automatic step_cycle();
    for (int i = 0; i < N; i++) begin
      if (drop_at[i] == k) begin rq[i] = 0; drop_at[i] = -1; end
      else if (rand_en && !rq[i] && drop_at[i] < 0 && $urandom_range(5) == 0) begin
        rq[i] = 1;
        ridx[i] = ($urandom_range(7) == 0) ? IW'($urandom_range(31, 25)) : IW'($urandom_range(24));
      end else if (rand_en && rq[i] && j_act && j_g == i && $urandom_range(9) == 0) ridx[i] = IW'($urandom);
      req_idx[i*IW +: IW] = ridx[i];
    end
    req = rq;
    calc_done = 0;
    calc_fibo_out = DW'($urandom);
    if (k == done_at) begin calc_done = 1; calc_fibo_out = fib(int'(calc_latched)); end
    else if (rand_en && !(j_act && j_legal && j_ack < 0 && k >= j_t + 2) && $urandom_range(7) == 0) calc_done = 1;
    model_step();
    @(posedge clk);
    #1;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("err", 32'(err), 32'(e_err));
    chk("result", 32'(result), 32'(e_res));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("calc_begin", 32'(calc_begin), 32'(e_begin));
    chk("calc_input_s", 32'(calc_input_s), 32'(e_in));
`ifdef FIBO_ARB_TIMEOUT_EN
    chk("timeout_seen", 32'(timeout_seen), 32'(e_to));
`endif
    if (calc_begin) begin
      begins++; last_in = calc_input_s; calc_latched = calc_input_s;
      done_at = (lat_fix == -2) ? -1 : k + 1 + ((lat_fix > 0) ? lat_fix : int'($urandom_range(12, 1)));
    end
    for (int i = 0; i < N; i++) if (e_ack[i]) drop_at[i] = k + ((rand_en && $urandom_range(1) == 1) ? 1 : 3);
    if (|ack) begin
      for (int i = 0; i < N; i++) if (ack[i]) ack_log.push_back(i);
      res_log.push_back(result);
      err_log.push_back(|err);
    end
    k++;
  endtask
  task automatic run_idle(string name, int budget);
    int n = 0;
    while ((j_act || |rq) && n < budget) begin step_cycle(); n++; end
    chk({name, "_finished"}, 32'(j_act || |rq), 0);
  endtask
  task automatic clear_logs();
    ack_log.delete(); res_log.delete(); err_log.delete();
  endtask
  function automatic int log_g(int i);
    return (ack_log.size() > i) ? ack_log[i] : -1;
  endfunction
  initial begin
    int b0;
    int seq_idx [3] = '{0, 1, 24};
    logic [DW-1:0] seq_res [3] = '{16'd0, 16'd1, 16'd46368};
    rq = '0; req = '0; req_idx = '0; calc_done = 0; calc_fibo_out = '0;
    calc_latched = '0; last_in = '0;
    for (int i = 0; i < N; i++) begin drop_at[i] = -1; ridx[i] = '0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 0); chk("rst_err", 32'(err), 0); chk("rst_result", 32'(result), 0);
    chk("rst_busy", 32'(busy), 0); chk("rst_begin", 32'(calc_begin), 0); chk("rst_input", 32'(calc_input_s), 0);
    reset_n = 1;
    // Simultaneous requests from reset priority, then rr=3 favours requester 0.
    clear_logs();
    rq[0] = 1; ridx[0] = 3; rq[2] = 1; ridx[2] = 4; rq[3] = 1; ridx[3] = 5;
    run_idle("rr3", 300);
    chk("rr3_count", ack_log.size(), 3);
    chk("rr3_g0", log_g(0), 0); chk("rr3_g1", log_g(1), 2); chk("rr3_g2", log_g(2), 3);
    clear_logs();
    rq[0] = 1; ridx[0] = 6; rq[3] = 1; ridx[3] = 7;
    run_idle("rr2", 200);
    chk("rr2_g0", log_g(0), 0); chk("rr2_g1", log_g(1), 3);
    // Single job idx=10 with a 10-cycle calculator.
    clear_logs(); lat_fix = 10; b0 = begins;
    rq[0] = 1; ridx[0] = 10;
    run_idle("fib10", 100);
    chk("fib10_begins", begins - b0, 1); chk("fib10_input", 32'(last_in), 10);
    chk("fib10_g", log_g(0), 0); chk("fib10_err", (err_log.size() > 0) ? err_log[0] : 1, 0);
    chk("fib10_result", (res_log.size() > 0) ? 32'(res_log[0]) : 32'hdead, 55);
    chk("pin_model_res", 32'(e_res), 55);
    lat_fix = -1;
    // Boundary indices on requester 2, one ack each (no hold-off re-grant).
    for (int s = 0; s < 3; s++) begin
      clear_logs();
      rq[2] = 1; ridx[2] = IW'(seq_idx[s]);
      run_idle("seq", 100);
      chk("seq_acks", ack_log.size(), 1); chk("seq_g", log_g(0), 2);
      chk("seq_result", (res_log.size() > 0) ? 32'(res_log[0]) : 32'hdead, 32'(seq_res[s]));
    end
    // Overflowing index is rejected without the calculator.
    clear_logs(); b0 = begins;
    rq[1] = 1; ridx[1] = 25;
    run_idle("ovf", 50);
    chk("ovf_begins", begins - b0, 0); chk("ovf_g", log_g(0), 1);
    chk("ovf_err", (err_log.size() > 0) ? err_log[0] : 0, 1);
    chk("ovf_result", (res_log.size() > 0) ? 32'(res_log[0]) : 32'hdead, 0);
    // Random traffic.
    rand_en = 1;
    repeat (3000) step_cycle();
    rand_en = 0;
    run_idle("random", 300);
    // Reset during WAIT drops the job.
    clear_logs(); lat_fix = 30;
    rq[0] = 1; ridx[0] = 10;
    for (int n = 0; n < 20 && !(j_act && k >= j_t + 4); n++) step_cycle();
    chk("wait_reached", 32'(j_act && k >= j_t + 4), 1);
    #2 reset_n = 0;
    #1;
    chk("arst_ack", 32'(ack), 0); chk("arst_err", 32'(err), 0); chk("arst_result", 32'(result), 0);
    chk("arst_busy", 32'(busy), 0); chk("arst_begin", 32'(calc_begin), 0); chk("arst_input", 32'(calc_input_s), 0);
    rq = '0; req = '0; done_at = -1; lat_fix = -1;
    for (int i = 0; i < N; i++) drop_at[i] = -1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("arst_noack", 32'(ack), 0);
    reset_n = 1;
    rq[0] = 1; ridx[0] = 5;
    run_idle("post_rst", 100);
    chk("post_rst_acks", ack_log.size(), 1); chk("post_rst_g", log_g(0), 0);
    chk("post_rst_result", (res_log.size() > 0) ? 32'(res_log[0]) : 32'hdead, 5);
`ifdef FIBO_ARB_TIMEOUT_EN
    clear_logs(); lat_fix = -2;
    rq[3] = 1; ridx[3] = 7;
    run_idle("timeout", 150);
    chk("to_g", log_g(0), 3); chk("to_err", (err_log.size() > 0) ? err_log[0] : 0, 1);
    chk("to_result", (res_log.size() > 0) ? 32'(res_log[0]) : 32'hdead, 0);
    chk("to_seen", 32'(timeout_seen), 1);
    lat_fix = -1;
    repeat (5) step_cycle();
    chk("to_sticky", 32'(timeout_seen), 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
